// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges two write-back requesters (ALU, memory) into one register-file
// write port, with per-register pending-write counts for hazard queries.
// Revision 1.0
`default_nettype none

module wb_port_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in0_valid,
  output logic                    in0_ready,
  input  logic [ADDRESS_SIZE-1:0] in0_dest,
  input  logic [WORD_SIZE-1:0]    in0_data,
  input  logic                    in1_valid,
  output logic                    in1_ready,
  input  logic [ADDRESS_SIZE-1:0] in1_dest,
  input  logic [WORD_SIZE-1:0]    in1_data,
  input  logic [ADDRESS_SIZE-1:0] hz_src1,
  input  logic [ADDRESS_SIZE-1:0] hz_src2,
  output logic                    hz_src1_busy,
  output logic                    hz_src2_busy,
  output logic                    wb_en,
  output logic [ADDRESS_SIZE-1:0] wb_dest,
  output logic [WORD_SIZE-1:0]    wb_data,
  output logic                    grant_id,
  output logic                    drop_err,
  output logic                    idle
);

  localparam int                      NUM_REGS  = 2 ** ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE-1:0] DROP_DEST = '1;

  // Register 0 and the drop address never carry a pending write.
  function automatic logic tracked(input logic [ADDRESS_SIZE-1:0] a);
    return (a != '0) && (a != DROP_DEST);
  endfunction

  logic                    full0_q, full0_d, full1_q, full1_d;
  logic [ADDRESS_SIZE-1:0] dest0_q, dest0_d, dest1_q, dest1_d;
  logic [WORD_SIZE-1:0]    data0_q, data0_d, data1_q, data1_d;
  logic                    last_q, last_d;
  logic                    wb_en_q, wb_en_d;
  logic [ADDRESS_SIZE-1:0] wb_dest_q, wb_dest_d;
  logic [WORD_SIZE-1:0]    wb_data_q, wb_data_d;
  logic                    grant_id_q, grant_id_d;
  logic                    drop_err_q, drop_err_d;
  logic [1:0]              cnt_q   [NUM_REGS];
  logic [1:0]              cnt_d   [NUM_REGS];
  logic [3:0]              cnt_sum [NUM_REGS];

  logic                    grant0, grant1, any_grant;
  logic                    acc0, acc1, inc0, inc1, dec, win_drop;
  logic [ADDRESS_SIZE-1:0] win_dest;
  logic [WORD_SIZE-1:0]    win_data;

  // last_q holds the most recent winner; the other source takes a tie.
  assign grant0    = full0_q & (~full1_q | last_q);
  assign grant1    = full1_q & (~full0_q | ~last_q);
  assign any_grant = grant0 | grant1;
  assign win_dest  = grant1 ? dest1_q : dest0_q;
  assign win_data  = grant1 ? data1_q : data0_q;
  assign win_drop  = (win_dest == DROP_DEST);

  assign in0_ready = ~full0_q | grant0;
  assign in1_ready = ~full1_q | grant1;
  assign acc0      = in0_valid & in0_ready;
  assign acc1      = in1_valid & in1_ready;
  assign inc0      = acc0 & tracked(in0_dest);
  assign inc1      = acc1 & tracked(in1_dest);
  assign dec       = any_grant & tracked(win_dest);

  always_comb begin
    full0_d = full0_q;
    dest0_d = dest0_q;
    data0_d = data0_q;
    full1_d = full1_q;
    dest1_d = dest1_q;
    data1_d = data1_q;
    if (acc0) begin
      full0_d = 1'b1;
      dest0_d = in0_dest;
      data0_d = in0_data;
    end else if (grant0) begin
      full0_d = 1'b0;
    end
    if (acc1) begin
      full1_d = 1'b1;
      dest1_d = in1_dest;
      data1_d = in1_data;
    end else if (grant1) begin
      full1_d = 1'b0;
    end
  end

  // A dropped entry still advances the pointer but leaves the write port untouched.
  always_comb begin
    last_d     = any_grant ? grant1 : last_q;
    wb_en_d    = any_grant & ~win_drop;
    drop_err_d = any_grant & win_drop;
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;
    grant_id_d = grant_id_q;
    if (any_grant && !win_drop) begin
      wb_dest_d  = win_dest;
      wb_data_d  = win_data;
      grant_id_d = grant1;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_sum[r] = {2'b00, cnt_q[r]};
      if (inc0 && in0_dest == ADDRESS_SIZE'(r)) cnt_sum[r] = cnt_sum[r] + 4'd1;
      if (inc1 && in1_dest == ADDRESS_SIZE'(r)) cnt_sum[r] = cnt_sum[r] + 4'd1;
      if (dec && win_dest == ADDRESS_SIZE'(r))  cnt_sum[r] = cnt_sum[r] - 4'd1;
      cnt_d[r] = cnt_sum[r][1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full0_q    <= 1'b0;
      dest0_q    <= '0;
      data0_q    <= '0;
      full1_q    <= 1'b0;
      dest1_q    <= '0;
      data1_q    <= '0;
      last_q     <= 1'b1;
      wb_en_q    <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      grant_id_q <= 1'b0;
      drop_err_q <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= 2'b00;
    end else begin
      full0_q    <= full0_d;
      dest0_q    <= dest0_d;
      data0_q    <= data0_d;
      full1_q    <= full1_d;
      dest1_q    <= dest1_d;
      data1_q    <= data1_d;
      last_q     <= last_d;
      wb_en_q    <= wb_en_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
      grant_id_q <= grant_id_d;
      drop_err_q <= drop_err_d;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // Only two buffers exist, so a count above 2 or a wrap below 0 is a logic error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) assert (cnt_sum[r] <= 4'd2);
    end
  end

  assign hz_src1_busy = (cnt_q[hz_src1] != 2'b00);
  assign hz_src2_busy = (cnt_q[hz_src2] != 2'b00);
  assign wb_en        = wb_en_q;
  assign wb_dest      = wb_dest_q;
  assign wb_data      = wb_data_q;
  assign grant_id     = grant_id_q;
  assign drop_err     = drop_err_q;
  assign idle         = ~full0_q & ~full1_q & ~wb_en_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter with hand-computed expectations.
`default_nettype none

module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in0_valid = 1'b0, in1_valid = 1'b0;
  logic        in0_ready, in1_ready;
  logic [3:0]  in0_dest = '0, in1_dest = '0;
  logic [31:0] in0_data = '0, in1_data = '0;
  logic [3:0]  hz_src1 = '0, hz_src2 = '0;
  logic        hz_src1_busy, hz_src2_busy;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
  logic        grant_id, drop_err, idle;

  int vectors = 0;
  int miscompares = 0;

  wb_port_arbiter #(.WORD_SIZE(32), .ADDRESS_SIZE(4)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_dest(in0_dest), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_dest(in1_dest), .in1_data(in1_data),
    .hz_src1(hz_src1), .hz_src2(hz_src2),
    .hz_src1_busy(hz_src1_busy), .hz_src2_busy(hz_src2_busy),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .grant_id(grant_id), .drop_err(drop_err), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_wb_dest", 32'(wb_dest), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_drop_err", 32'(drop_err), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_in0_ready", 32'(in0_ready), 1);
    chk("rst_in1_ready", 32'(in1_ready), 1);
    rst = 1'b0;

    // single offer from in0
    in0_valid = 1'b1; in0_dest = 4'd3; in0_data = 32'hA5; hz_src1 = 4'd3;
    #1;
    chk("t1_in0_ready", 32'(in0_ready), 1);
    step();
    in0_valid = 1'b0;
    #1;
    chk("t1_busy_pending", 32'(hz_src1_busy), 1);
    chk("t1_not_idle", 32'(idle), 0);
    step();
    chk("t1_wb_en", 32'(wb_en), 1);
    chk("t1_wb_dest", 32'(wb_dest), 3);
    chk("t1_wb_data", wb_data, 32'hA5);
    chk("t1_grant_id", 32'(grant_id), 0);
    chk("t1_busy_clear", 32'(hz_src1_busy), 0);
    step();
    chk("t1_wb_en_off", 32'(wb_en), 0);
    chk("t1_wb_dest_hold", 32'(wb_dest), 3);
    chk("t1_idle", 32'(idle), 1);

    // fresh reset so the round-robin starts from in0
    #2 rst = 1'b1;
    #1 rst = 1'b0;

    // both valid every cycle: grant alternates 0,1,0,1
    in0_valid = 1'b1; in0_dest = 4'd4; in0_data = 32'h1000_0004;
    in1_valid = 1'b1; in1_dest = 4'd5; in1_data = 32'h2000_0005;
    hz_src1 = 4'd4; hz_src2 = 4'd5;
    step();
    chk("t2_in0_ready_c1", 32'(in0_ready), 1);
    chk("t2_in1_ready_c1", 32'(in1_ready), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t2_wb_en_%0d", i), 32'(wb_en), 1);
      chk($sformatf("t2_grant_%0d", i), 32'(grant_id), 32'(i % 2));
      chk($sformatf("t2_dest_%0d", i), 32'(wb_dest), (i % 2 == 0) ? 4 : 5);
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    step();
    chk("t2_drain_grant", 32'(grant_id), 0);
    step();
    chk("t2_drain_grant2", 32'(grant_id), 1);
    chk("t2_drain_data", wb_data, 32'h2000_0005);
    step();
    chk("t2_idle", 32'(idle), 1);
    chk("t2_busy4", 32'(hz_src1_busy), 0);
    chk("t2_busy5", 32'(hz_src2_busy), 0);

    // both offer dest 7 on one edge: busy holds through the first write
    in0_valid = 1'b1; in0_dest = 4'd7; in0_data = 32'h77;
    in1_valid = 1'b1; in1_dest = 4'd7; in1_data = 32'h78;
    hz_src1 = 4'd7;
    step();
    in0_valid = 1'b0; in1_valid = 1'b0;
    #1;
    chk("t3_busy_c1", 32'(hz_src1_busy), 1);
    step();
    chk("t3_wb_en_1", 32'(wb_en), 1);
    chk("t3_data_1", wb_data, 32'h77);
    chk("t3_busy_first_wr", 32'(hz_src1_busy), 1);
    step();
    chk("t3_wb_en_2", 32'(wb_en), 1);
    chk("t3_data_2", wb_data, 32'h78);
    chk("t3_grant_2", 32'(grant_id), 1);
    chk("t3_busy_second_wr", 32'(hz_src1_busy), 0);
    step();
    chk("t3_idle", 32'(idle), 1);

    // in1 offers dest 15: dropped with a one-cycle drop_err
    in1_valid = 1'b1; in1_dest = 4'd15; in1_data = 32'hFF; hz_src2 = 4'd15;
    #1;
    chk("t4_in1_ready_c0", 32'(in1_ready), 1);
    step();
    in1_valid = 1'b0;
    #1;
    chk("t4_in1_ready_c1", 32'(in1_ready), 1);
    chk("t4_busy15", 32'(hz_src2_busy), 0);
    chk("t4_drop_c1", 32'(drop_err), 0);
    step();
    chk("t4_drop_c2", 32'(drop_err), 1);
    chk("t4_wb_en_c2", 32'(wb_en), 0);
    step();
    chk("t4_drop_c3", 32'(drop_err), 0);
    chk("t4_idle", 32'(idle), 1);

    // dest 0 forwarded, busy never raised for 0 or 15
    in0_valid = 1'b1; in0_dest = 4'd0; in0_data = 32'h11;
    in1_valid = 1'b1; in1_dest = 4'd15; in1_data = 32'h22;
    hz_src1 = 4'd0; hz_src2 = 4'd15;
    step();
    in0_valid = 1'b0; in1_valid = 1'b0;
    #1;
    chk("t5_busy0", 32'(hz_src1_busy), 0);
    chk("t5_busy15", 32'(hz_src2_busy), 0);
    step();
    chk("t5_wb_en", 32'(wb_en), 1);
    chk("t5_wb_dest", 32'(wb_dest), 0);
    chk("t5_wb_data", wb_data, 32'h11);
    step();
    chk("t5_drop", 32'(drop_err), 1);
    chk("t5_wb_en_off", 32'(wb_en), 0);
    step();

    // reset with both buffers full
    in0_valid = 1'b1; in0_dest = 4'd9;  in0_data = 32'h99;
    in1_valid = 1'b1; in1_dest = 4'd10; in1_data = 32'hAA;
    hz_src1 = 4'd9; hz_src2 = 4'd10;
    step();
    in0_valid = 1'b0; in1_valid = 1'b0;
    #1;
    chk("t6_busy9_pre", 32'(hz_src1_busy), 1);
    chk("t6_busy10_pre", 32'(hz_src2_busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_wb_en", 32'(wb_en), 0);
    chk("t6_rst_idle", 32'(idle), 1);
    chk("t6_rst_busy9", 32'(hz_src1_busy), 0);
    chk("t6_rst_busy10", 32'(hz_src2_busy), 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_post_wb_en", 32'(wb_en), 0);
    chk("t6_post_idle", 32'(idle), 1);
    step();
    chk("t6_post_wb_en2", 32'(wb_en), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data width of all write-back data.
REQ-002 SHALL have parameter ADDRESS_SIZE, default 4, register-address width.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in0_valid / in1_valid  input  1  requester n offers a write (n=0 ALU path, n=1 memory path).
REQ-006 SHALL have ports in0_ready / in1_ready  output  1  requester n entry accepted at this rising edge if valid.
REQ-007 SHALL have ports in0_dest / in1_dest  input  ADDRESS_SIZE  destination register of the offer.
REQ-008 SHALL have ports in0_data / in1_data  input  WORD_SIZE  data of the offer.
REQ-009 SHALL have ports hz_src1 / hz_src2  input  ADDRESS_SIZE  registers queried for pending writes.
REQ-010 SHALL have ports hz_src1_busy / hz_src2_busy  output  1  queried register has a write pending (combinational).
REQ-011 SHALL have port wb_en  output  1  register-file write enable, registered.
REQ-012 SHALL have port wb_dest  output  ADDRESS_SIZE  register-file write address, registered.
REQ-013 SHALL have port wb_data  output  WORD_SIZE  register-file write data, registered.
REQ-014 SHALL have port grant_id  output  1  source of the current wb_* contents, registered.
REQ-015 SHALL have port drop_err  output  1  one-cycle pulse: an entry with dest 15 was discarded.
REQ-016 SHALL have port idle  output  1  both buffers empty and wb_en low.

Function
REQ-017 SHALL hold one entry (dest, data) per requester in a holding buffer with a full flag.
REQ-018 SHALL accept an offer at a rising edge when in_n_valid and in_n_ready are both high; buffer becomes full next cycle.
REQ-019 SHALL drive in_n_ready = !full_n | grant_n, where grant_n is this cycle's arbitration result (no dependence on valid); one entry per cycle per requester at full throughput.
REQ-020 SHALL arbitrate each cycle among full buffers: single full buffer wins; both full -> the source not granted last wins (round-robin pointer updated on every grant).
REQ-021 SHALL, at the edge ending a granted cycle, load wb_dest, wb_data, grant_id from the winner and set wb_en=1; latency accept-to-wb_en is 1 cycle minimum, 2 cycles when losing arbitration.
REQ-022 SHALL, in a cycle with no grant, clear wb_en and hold wb_dest, wb_data, grant_id.
REQ-023 SHALL treat a winning entry with dest 15 as a grant that drains the buffer and advances the pointer but leaves wb_en=0 and pulses drop_err for one cycle.
REQ-024 SHALL forward dest 0 entries normally (wb_en=1); scoreboard does not track register 0.
REQ-025 SHALL keep a 2-bit pending count per register 1..14: +1 on acceptance, -1 at the grant edge of that entry; simultaneous +1/-1 on the same register leaves it unchanged; two same-register accepts in one edge add 2.
REQ-026 SHALL never exceed count 2 (two buffers) nor underflow; any other value is a design error flagged by assertion.
REQ-027 SHALL drive hz_srcX_busy = (count[hz_srcX] != 0); always 0 for addresses 0 and 15.
REQ-028 SHALL clear busy in the cycle wb_en is high for that entry (register file writes on that cycle's falling edge).
REQ-029 SHALL drive idle = !full_0 & !full_1 & !wb_en.

Reset
REQ-030 SHALL on rst: both buffers empty, all counts 0, wb_en=0, wb_dest=0, wb_data=0, grant_id=0, drop_err=0, pointer set so in0 wins the first tie.
REQ-031 SHALL on rst mid-operation discard buffered and in-flight entries with no wb_en pulse in the cycle following rst deassertion.

Verification
REQ-032 SHALL cover: in0 offers dest 3 data 0xA5 alone -> in0_ready=1, next cycle wb_en=1, wb_dest=3, wb_data=0xA5, grant_id=0.
REQ-033 SHALL cover: both valid every cycle, dest 4 / dest 5 -> wb_en held high, grant_id alternates 0,1,0,1 starting with 0 after reset.
REQ-034 SHALL cover: both offer dest 7 same edge -> hz busy for 7 stays 1 through first write, clears in cycle of second wb_en.
REQ-035 SHALL cover: in1 offers dest 15 -> no wb_en, drop_err=1 for exactly one cycle, in1_ready stays 1.
REQ-036 SHALL cover: rst asserted with both buffers full -> wb_en=0, idle=1, hz busy 0 for all registers.
REQ-037 SHALL cover: query hz_src1=0 and 15 during pending writes to 0 -> busy=0.
